hls_fp17_to_fp32_chn_o_skid: RTL

- Output-channel interface stage directly downstream of the fp17_to_fp32 core datapath and its staller.
- Accepts each converted fp32 result from the core and buffers it in a small FIFO (default 2 entries).
- Presents the result to the downstream consumer over a valid/ready handshake.
- Returns chn_o_rsci_wen_comp to the staller, so the core stalls whenever the buffer cannot take a result.
- wen_comp is derived from registered state only; there is no combinational path from chn_o_prdy to the core enable.

---
 rtl/hls_fp17_to_fp32_pkg.sv | 13 +
 rtl/hls_fp17_to_fp32_fifo_mem.sv | 39 +++
 rtl/hls_fp17_to_fp32_chn_o_skid.sv | 89 ++++++++
 3 files changed

// File: rtl/hls_fp17_to_fp32_pkg.sv
// Shared constants and payload type for the fp17_to_fp32 conversion block.
//   FP32_W     : fp32 result width
//   FP17_W     : fp17 input width
//   SKID_DEPTH : default output skid buffer depth
package hls_fp17_to_fp32_pkg;

    localparam int unsigned FP32_W     = 32;
    localparam int unsigned FP17_W     = 17;
    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [FP32_W-1:0] fp32_t;

endpackage : hls_fp17_to_fp32_pkg

// File: rtl/hls_fp17_to_fp32_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read,
// all entries cleared by the synchronous active-low reset.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from the array)
module hls_fp17_to_fp32_fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage array
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : hls_fp17_to_fp32_fifo_mem

// File: rtl/hls_fp17_to_fp32_chn_o_skid.sv
// Output-channel skid buffer behind the fp17_to_fp32 core. Buffers converted
// results in a small FIFO, presents them on a valid/ready channel and tells
// the staller whether the core may advance.
//   nvdla_core_clk      : clock
//   nvdla_core_rstn     : synchronous active-low reset
//   core_wen            : core advance enable from the staller
//   core_o_ld           : core presents a result this cycle
//   core_o_dat          : result payload
//   chn_o_rsci_wen_comp : 1 = output side does not block the core
//   chn_o_pvld/prdy/pd  : downstream valid/ready/payload
//   chn_o_cnt           : current occupancy
module hls_fp17_to_fp32_chn_o_skid
    import hls_fp17_to_fp32_pkg::*;
#(
    parameter int unsigned WIDTH = FP32_W,
    parameter int unsigned DEPTH = SKID_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             core_wen,
    input  logic             core_o_ld,
    input  logic [WIDTH-1:0] core_o_dat,
    output logic             chn_o_rsci_wen_comp,
    output logic             chn_o_pvld,
    input  logic             chn_o_prdy,
    output logic [WIDTH-1:0] chn_o_pd,
    output logic [CW-1:0]    chn_o_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == CW'(0));
    assign push  = core_wen & core_o_ld;
    assign pop   = chn_o_pvld & chn_o_prdy;

    // Stall request depends only on the registered fill level, never on prdy
    assign chn_o_rsci_wen_comp = ~core_o_ld | ~full;
    assign chn_o_pvld          = ~empty;
    assign chn_o_cnt           = count_q;

    // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Control registers
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    hls_fp17_to_fp32_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (nvdla_core_clk),
        .rst_ni  (nvdla_core_rstn),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (core_o_dat),
        .raddr_i (rd_ptr_q),
        .rdata_o (chn_o_pd)
    );

endmodule : hls_fp17_to_fp32_chn_o_skid
